// File: rtl/eth_rx_frame_fifo_pkg.sv
// eth_rx_fifo_pkg
// Shared types for the receive frame FIFO:
//   wr_state_e    - write-side frame FSM states
//   ETH_MIN_FRAME - minimum legal Ethernet frame length in bytes
//   fifo_entry_t  - one buffered byte plus its end-of-frame marker
package eth_rx_fifo_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        WRITE,
        DROP
    } wr_state_e;

    localparam int unsigned ETH_MIN_FRAME = 64;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/eth_rx_frame_fifo_if.sv
// eth_rx_frame_fifo_if
// 8-bit AXI-Stream bundle used on both sides of the receive frame FIFO.
//   tdata  - byte
//   tvalid - byte valid
//   tlast  - last byte of frame
//   tuser  - frame error, meaningful with tlast
//   tready - sink ready
// master: drives tdata/tvalid/tlast/tuser, samples tready.
// slave : samples tdata/tvalid/tlast/tuser, drives tready.
interface eth_rx_frame_fifo_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;
    logic       tready;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/eth_rx_frame_fifo_ram.sv
// eth_fifo_ram
// Simple dual-port RAM, DEPTH x fifo_entry_t, synchronous read. Kept free
// of reset and extra logic so it maps onto FPGA block RAM.
//   clk     - single clock
//   wr_en   - write strobe
//   wr_addr - write address
//   wr_data - entry to store
//   rd_en   - read strobe; rd_data holds its value while low
//   rd_addr - read address
//   rd_data - registered read data
module eth_fifo_ram
    import eth_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  fifo_entry_t       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output fifo_entry_t       rd_data
);

    fifo_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo
// Store-and-forward receive frame FIFO behind the RGMII MAC receive stream.
// Frames are buffered whole and released only after a good tlast; frames
// marked bad by the MAC or that overflow the buffer are rolled back and
// counted.
//   clk          - 125 MHz MAC clock
//   rst_n        - asynchronous active-low reset
//   s_axis       - input stream from MAC (tready tied high, never stalls)
//   m_axis       - buffered output stream, honours tready
//   drop_bad_cnt - saturating count of frames dropped for tuser (or runt)
//   drop_ovf_cnt - saturating count of frames dropped for overflow
//   frame_avail  - a committed frame is not yet fully read
// Optional build macro ETH_RX_RUNT_FILTER_EN: drop good frames shorter than
// ETH_MIN_FRAME bytes, counted in drop_bad_cnt.
module eth_rx_frame_fifo
    import eth_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    eth_rx_frame_fifo_if.slave       s_axis,
    eth_rx_frame_fifo_if.master      m_axis,
    output logic [CNT_W-1:0]         drop_bad_cnt,
    output logic [CNT_W-1:0]         drop_ovf_cnt,
    output logic                     frame_avail
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    wr_state_e   state, state_nx;
    ptr_t        wr_ptr, wr_ptr_nx;
    ptr_t        wr_commit, wr_commit_nx;
    ptr_t        rd_ptr;
    logic        wr_en;
    logic        bad_inc;
    logic        ovf_inc;
    logic        full;
    logic        readable;
    logic        rd_en;
    logic        rd_issue;
    logic        runt;
    logic        out_valid;
    fifo_entry_t wr_entry;
    fifo_entry_t rd_entry;

    assign s_axis.tready = 1'b1;

    // Full uses the registered rd_ptr, so a same-cycle read is not credited.
    assign full     = (wr_ptr - rd_ptr) == ptr_t'(DEPTH);
    assign readable = rd_ptr != wr_commit;
    assign wr_entry = '{last: s_axis.tlast, data: s_axis.tdata};

`ifdef ETH_RX_RUNT_FILTER_EN
    // Bytes accepted before the current one; saturates so long frames never wrap.
    logic [6:0] len_cnt;

    assign runt = len_cnt < 7'(ETH_MIN_FRAME - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt <= '0;
        end else if (state_nx != WRITE) begin
            len_cnt <= '0;
        end else if (wr_en && len_cnt != '1) begin
            len_cnt <= len_cnt + 7'd1;
        end
    end
`else
    assign runt = 1'b0;
`endif

    // ---------------- write side ----------------
    always_comb begin
        state_nx     = state;
        wr_ptr_nx    = wr_ptr;
        wr_commit_nx = wr_commit;
        wr_en        = 1'b0;
        bad_inc      = 1'b0;
        ovf_inc      = 1'b0;
        case (state)
            SYNC: begin
                if (!s_axis.tvalid) begin
                    state_nx = IDLE;
                end
            end
            IDLE, WRITE: begin
                if (s_axis.tvalid) begin
                    if (full) begin
                        wr_ptr_nx = wr_commit;
                        ovf_inc   = 1'b1;
                        state_nx  = s_axis.tlast ? IDLE : DROP;
                    end else begin
                        wr_en = 1'b1;
                        if (!s_axis.tlast) begin
                            wr_ptr_nx = wr_ptr + ptr_t'(1);
                            state_nx  = WRITE;
                        end else if (s_axis.tuser || runt) begin
                            wr_ptr_nx = wr_commit;
                            bad_inc   = 1'b1;
                            state_nx  = IDLE;
                        end else begin
                            wr_ptr_nx    = wr_ptr + ptr_t'(1);
                            wr_commit_nx = wr_ptr + ptr_t'(1);
                            state_nx     = IDLE;
                        end
                    end
                end
            end
            DROP: begin
                if (s_axis.tvalid && s_axis.tlast) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SYNC;
            wr_ptr    <= '0;
            wr_commit <= '0;
        end else begin
            state     <= state_nx;
            wr_ptr    <= wr_ptr_nx;
            wr_commit <= wr_commit_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_bad_cnt <= '0;
            drop_ovf_cnt <= '0;
        end else begin
            if (bad_inc && drop_bad_cnt != '1) begin
                drop_bad_cnt <= drop_bad_cnt + CNT_W'(1);
            end
            if (ovf_inc && drop_ovf_cnt != '1) begin
                drop_ovf_cnt <= drop_ovf_cnt + CNT_W'(1);
            end
        end
    end

    // ---------------- read side ----------------
    // The RAM read register is the output register: a read is issued only
    // when that register is empty or being consumed, and it holds while
    // stalled. out_valid masks it so the outputs read zero after reset.
    assign rd_en    = !out_valid || m_axis.tready;
    assign rd_issue = rd_en && readable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else if (rd_en) begin
            out_valid <= readable;
            if (readable) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

    eth_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_entry),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_entry)
    );

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_valid ? rd_entry.data : '0;
    assign m_axis.tlast  = out_valid & rd_entry.last;
    assign m_axis.tuser  = 1'b0;

    assign frame_avail = readable | out_valid;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb_eth_rx_frame_fifo
// Bench for eth_rx_frame_fifo. dut_a uses the default depth; dut_b is a
// 64-byte buffer with 2-bit counters for overflow and saturation cases.
// Both see the same input stream and the same tready.
`timescale 1ns/1ps
module tb_eth_rx_frame_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_user;
    logic       ready;
    logic       rand_ready;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int last_cyc;
    int rise_cyc;

    always #4 clk = ~clk;
    always @(posedge clk) cyc++;

    eth_rx_frame_fifo_if s_a ();
    eth_rx_frame_fifo_if m_a ();
    eth_rx_frame_fifo_if s_b ();
    eth_rx_frame_fifo_if m_b ();

    assign s_a.tdata  = in_data;
    assign s_a.tvalid = in_valid;
    assign s_a.tlast  = in_last;
    assign s_a.tuser  = in_user;
    assign s_b.tdata  = in_data;
    assign s_b.tvalid = in_valid;
    assign s_b.tlast  = in_last;
    assign s_b.tuser  = in_user;
    assign m_a.tready = ready;
    assign m_b.tready = ready;

    logic [15:0] bad_a, ovf_a;
    logic        avail_a;
    logic [1:0]  bad_b, ovf_b;
    logic        avail_b;

    eth_rx_frame_fifo #(.DEPTH(4096), .CNT_W(16)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis       (s_a),
        .m_axis       (m_a),
        .drop_bad_cnt (bad_a),
        .drop_ovf_cnt (ovf_a),
        .frame_avail  (avail_a)
    );

    eth_rx_frame_fifo #(.DEPTH(64), .CNT_W(2)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis       (s_b),
        .m_axis       (m_b),
        .drop_bad_cnt (bad_b),
        .drop_ovf_cnt (ovf_b),
        .frame_avail  (avail_b)
    );

`ifdef ETH_RX_RUNT_FILTER_EN
    localparam int OVF_LEN1 = 64;
    localparam int OVF_LEN3 = 64;
`else
    localparam int OVF_LEN1 = 60;
    localparam int OVF_LEN3 = 30;
`endif

    // ---------------- output monitor ----------------
    logic [8:0] rx_a[$];
    logic [8:0] rx_b[$];
    logic       prev_stall_a;
    logic       prev_valid_a;
    logic [8:0] prev_word_a;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall_a = 1'b0;
            prev_valid_a = 1'b0;
        end else begin
            if (prev_stall_a) begin
                ntests++;
                if (!m_a.tvalid || {m_a.tlast, m_a.tdata} != prev_word_a) begin
                    nfail++;
                    $display("FAIL stall_hold: got valid=%0b word=%h, required valid=1 word=%h",
                             m_a.tvalid, {m_a.tlast, m_a.tdata}, prev_word_a);
                end
            end
            if (m_a.tvalid && !prev_valid_a && rise_cyc < 0) rise_cyc = cyc;
            if (m_a.tvalid && ready) rx_a.push_back({m_a.tlast, m_a.tdata});
            if (m_b.tvalid && ready) rx_b.push_back({m_b.tlast, m_b.tdata});
            prev_stall_a = m_a.tvalid && !ready;
            prev_word_a  = {m_a.tlast, m_a.tdata};
            prev_valid_a = m_a.tvalid;
        end
    end

    // ---------------- helpers ----------------
    function automatic int rx_size(input int sel);
        return (sel != 0) ? rx_b.size() : rx_a.size();
    endfunction

    function automatic logic [8:0] rx_at(input int sel, input int idx);
        return (sel != 0) ? rx_b[idx] : rx_a[idx];
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input int sel, input int off,
                             input int len, input int start);
        int         bad_idx;
        logic [8:0] exp_w;
        logic [8:0] got_w;
        logic [8:0] bad_got;
        logic [8:0] bad_exp;
        bad_idx = -1;
        bad_got = '0;
        bad_exp = '0;
        ntests++;
        if (rx_size(sel) < off + len) begin
            nfail++;
            $display("FAIL %s: got %0d bytes, required at least %0d", name, rx_size(sel), off + len);
            return;
        end
        for (int i = 0; i < len; i++) begin
            exp_w = {(i == len - 1), 8'(start + i)};
            got_w = rx_at(sel, off + i);
            if (got_w != exp_w && bad_idx < 0) begin
                bad_idx = i;
                bad_got = got_w;
                bad_exp = exp_w;
            end
        end
        if (bad_idx >= 0) begin
            nfail++;
            $display("FAIL %s: byte %0d got {last,data}=%h, required %h", name, bad_idx, bad_got, bad_exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic last, input logic user);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_user  = user;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_user  = 1'b0;
    endtask

    task automatic send_frame(input int len, input int start, input bit bad);
        for (int i = 0; i < len; i++) begin
            tick();
            drive_byte(8'(start + i), (i == len - 1), bad && (i == len - 1));
            if (i == len - 1) last_cyc = cyc;
        end
        tick();
        drive_idle();
    endtask

    task automatic wait_rx(input int sel, input int n, input int budget);
        for (int c = 0; c < budget && rx_size(sel) < n; c++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        rx_a.delete();
        rx_b.delete();
    endtask

    // ---------------- frame table ----------------
    typedef struct {
        int len;
        int start;
        bit bad;
        bit rnd;
        bit deliver;
        int exp_bad;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_n;

        vecs[0] = '{100, 'h00, 1'b0, 1'b0, 1'b1, 0};
        vecs[1] = '{ 70, 'h10, 1'b1, 1'b0, 1'b0, 1};
        vecs[2] = '{ 80, 'h20, 1'b0, 1'b0, 1'b1, 1};
        vecs[3] = '{200, 'h05, 1'b0, 1'b1, 1'b1, 1};
`ifdef ETH_RX_RUNT_FILTER_EN
        vecs[4] = '{  1, 'hAA, 1'b0, 1'b0, 1'b0, 2};
        vecs[5] = '{  1, 'h3C, 1'b1, 1'b0, 1'b0, 3};
        vecs[6] = '{ 63, 'h40, 1'b0, 1'b0, 1'b0, 4};
        vecs[7] = '{ 64, 'h80, 1'b0, 1'b0, 1'b1, 4};
`else
        vecs[4] = '{  1, 'hAA, 1'b0, 1'b0, 1'b1, 1};
        vecs[5] = '{  1, 'h3C, 1'b1, 1'b0, 1'b0, 2};
        vecs[6] = '{ 63, 'h40, 1'b0, 1'b0, 1'b1, 2};
        vecs[7] = '{ 64, 'h80, 1'b0, 1'b0, 1'b1, 2};
`endif

        rst_n      = 1'b0;
        ready      = 1'b1;
        rand_ready = 1'b0;
        rise_cyc   = -1;
        last_cyc   = 0;
        drive_idle();

        // Reset state
        repeat (2) tick();
        chk("rst_tvalid", m_a.tvalid, 0);
        chk("rst_tdata", m_a.tdata, 0);
        chk("rst_tlast", m_a.tlast, 0);
        chk("rst_bad_cnt", bad_a, 0);
        chk("rst_ovf_cnt", ovf_a, 0);
        chk("rst_frame_avail", avail_a, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Table-driven frames on dut_a
        for (int v = 0; v < 8; v++) begin
            rx_a.delete();
            rise_cyc   = -1;
            ready      = 1'b1;
            rand_ready = vecs[v].rnd;
            send_frame(vecs[v].len, vecs[v].start, vecs[v].bad);
            exp_n = vecs[v].deliver ? vecs[v].len : 0;
            wait_rx(0, exp_n, 4 * vecs[v].len + 20);
            rand_ready = 1'b0;
            ready      = 1'b1;
            repeat (6) tick();
            chk($sformatf("v%0d_count", v), rx_a.size(), exp_n);
            if (vecs[v].deliver) begin
                chk_frame($sformatf("v%0d_data", v), 0, 0, vecs[v].len, vecs[v].start);
                chk($sformatf("v%0d_latency", v), rise_cyc - last_cyc, 2);
            end else begin
                chk($sformatf("v%0d_no_valid", v), rise_cyc, -1);
            end
            chk($sformatf("v%0d_bad_cnt", v), bad_a, vecs[v].exp_bad);
            chk($sformatf("v%0d_ovf_cnt", v), ovf_a, 0);
            chk($sformatf("v%0d_avail", v), avail_a, 0);
        end

        // Overflow on the 64-byte buffer
        do_reset();
        ready = 1'b0;
        send_frame(OVF_LEN1, 'h00, 1'b0);
        send_frame(20, 'h40, 1'b0);
        repeat (3) tick();
        chk("ovf_cnt", ovf_b, 1);
        chk("ovf_bad_cnt", bad_b, 0);
        chk("ovf_avail", avail_b, 1);
        chk("ovf_held", rx_b.size(), 0);
        ready = 1'b1;
        wait_rx(1, OVF_LEN1, 200);
        repeat (5) tick();
        chk("ovf_drain_count", rx_b.size(), OVF_LEN1);
        chk_frame("ovf_drain_data", 1, 0, OVF_LEN1, 'h00);
        chk("ovf_drain_avail", avail_b, 0);
        send_frame(OVF_LEN3, 'h80, 1'b0);
        wait_rx(1, OVF_LEN1 + OVF_LEN3, 200);
        repeat (5) tick();
        chk("ovf_next_count", rx_b.size(), OVF_LEN1 + OVF_LEN3);
        chk_frame("ovf_next_data", 1, OVF_LEN1, OVF_LEN3, 'h80);
        chk("ovf_next_ovf_cnt", ovf_b, 1);

        // Reset mid-frame while an output byte is stalled
        do_reset();
        ready = 1'b0;
        send_frame(80, 'h11, 1'b0);
        repeat (4) tick();
        chk("mid_stalled_valid", m_a.tvalid, 1);
        chk("mid_stalled_data", m_a.tdata, 'h11);
        for (int i = 0; i < 40; i++) begin
            tick();
            drive_byte(8'('h30 + i), 1'b0, 1'b0);
        end
        tick();
        drive_byte(8'('h30 + 40), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", m_a.tvalid, 0);
        chk("mid_rst_tdata", m_a.tdata, 0);
        chk("mid_rst_tlast", m_a.tlast, 0);
        chk("mid_rst_avail", avail_a, 0);
        rx_a.delete();
        for (int i = 41; i < 100; i++) begin
            tick();
            if (i == 44) rst_n = 1'b1;
            drive_byte(8'('h30 + i), (i == 99), 1'b0);
        end
        tick();
        drive_idle();
        ready = 1'b1;
        repeat (3) tick();
        send_frame(70, 'h55, 1'b0);
        wait_rx(0, 70, 300);
        repeat (6) tick();
        chk("mid_next_count", rx_a.size(), 70);
        chk_frame("mid_next_data", 0, 0, 70, 'h55);
        chk("mid_bad_cnt", bad_a, 0);
        chk("mid_ovf_cnt", ovf_a, 0);

        // Counter saturation on the 2-bit counters
        do_reset();
        for (int k = 0; k < 3; k++) send_frame(2, k, 1'b1);
        repeat (2) tick();
        chk("sat_bad_three", bad_b, 3);
        send_frame(2, 'h70, 1'b1);
        repeat (2) tick();
        chk("sat_bad_stuck", bad_b, 3);
        chk("sat_no_output", rx_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
